sipo_collector: RTL and testbench
=================================

Name: sipo_collector

Overview:
Serial-in, parallel-out collector. It is the receive end of the serial adder's shift interface. It accumulates WIDTH serial bits, LSB first, into a register, then presents the completed word with a valid/ack handshake. It sits after the serial adder's sum flop and turns the serial sum back into a parallel result for display or downstream logic.

Parameters:
WIDTH, 4, number of bits per word; legal range 2..16.
CNT_W, 5, counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset_n  input  1  synchronous reset, active-low.
clear  input  1  abort the partial word and return to IDLE; no output update.
shift  input  1  sample s_in this cycle.
s_in  input  1  serial data bit.
ack  input  1  consumer accepts p_out; meaningful only while valid=1.
p_out  output  WIDTH  last completed word; holds until the next completion.
valid  output  1  p_out holds an unacknowledged word.
busy  output  1  a partial word is in progress (bit_cnt != 0).
overrun  output  1  sticky flag: a word completed while valid=1.
bit_cnt  output  CNT_W  number of bits collected in the current word.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (ports clk, reset_n).
- Reset (reset_n=0 at a clk edge): shift register=0, p_out=0, valid=0, busy=0, overrun=0, bit_cnt=0, state=IDLE. Reset has priority over every other input, including in the middle of a word.
- Input priority below reset: clear > shift. ack is evaluated independently in the same cycle.
- Shift register update when shift=1: sr <= {s_in, sr[WIDTH-1:1]}. The first bit received lands in bit 0 after WIDTH shifts.
- States:
  - IDLE (bit_cnt=0): shift=1 moves to COLLECT with bit_cnt=1.
  - COLLECT: each shift increments bit_cnt.
  - On the shift that makes bit_cnt reach WIDTH, in the same edge:
    - p_out <= completed word, including the current s_in;
    - valid <= 1;
    - bit_cnt <= 0;
    - state <= IDLE.
  - Latency: p_out and valid update at the same edge that samples the last bit.
- No shift pulse leaves all state unchanged. Gaps between shift pulses are allowed.
- clear=1: bit_cnt <= 0, sr <= 0, state <= IDLE. p_out, valid and overrun are unaffected.
- Handshake:
  - valid drops the cycle after ack=1 is sampled while valid=1.
  - ack while valid=0 is ignored.
  - Completion and ack in the same cycle: valid stays 1 and p_out takes the new word. The old word counts as consumed, so overrun is not set.
- Overrun: a completion while valid=1 and ack=0 sets overrun=1 and overwrites p_out. overrun is cleared only by reset.
- busy is a registered copy of (bit_cnt != 0), aligned with bit_cnt.
- Timing pairing: the upstream parallel-to-serial stage drives its serial output one cycle after its shift enable. The integrating top delays that shift enable by one flop before driving this block's shift input.

Optional Feature:
Macro SIPO_MSB_FIRST_EN.
- Defined: sr <= {sr[WIDTH-2:0], s_in}, so the first bit received ends in bit WIDTH-1.
- Undefined (default): LSB-first, as above.
- Counter, handshake and overrun behaviour are identical in both builds.

Decomposition:
- Shared package serial_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_COLLECT=1'b1;
  - default word width SER_WIDTH=4.
- One sub-module is natural: sipo_bit_counter (CNT_W-bit counter).
  - Inputs: inc, clr, reset_n.
  - Terminal-count output at WIDTH-1 & inc.
- The FSM, shift register and handshake stay in sipo_collector.

Test Plan:
1. Reset, then 4 shifts with s_in = 1,0,1,1 (LSB-first build) -> p_out=4'b1101 and valid=1 on the 4th shift edge; busy=0; bit_cnt=0.
2. Same as 1, with ack asserted 3 cycles later -> valid=0 the cycle after ack; p_out still 4'b1101.
3. Complete word 4'hA with no ack, then word 4'h5 -> p_out=4'h5, valid=1, overrun=1. A further ack clears valid but not overrun.
4. Two shifts of bit 1, then clear, then 4 shifts of 0,0,0,1 -> p_out=4'h8; earlier partial bits discarded.
5. reset_n=0 mid-word after 3 shifts, and separately while valid=1 -> all outputs return to 0 on the next edge.
6. SIPO_MSB_FIRST_EN defined, s_in = 1,0,1,1 -> p_out=4'b1011. Also: ack coincident with the completing shift -> valid stays 1, overrun stays 0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial shift path: FSM state encoding and default word width.
package serial_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  localparam int SER_WIDTH = 4;

endpackage

// File: rtl/sipo_collector_if.sv
// Serial-in / parallel-out bundle: master drives serial bits and ack, slave returns the word.
interface sipo_collector_if
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  parameter int CNT_W = 5
);
  logic             clear;
  logic             shift;
  logic             s_in;
  logic             ack;
  logic [WIDTH-1:0] p_out;
  logic             valid;
  logic             busy;
  logic             overrun;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output clear, shift, s_in, ack,
    input  p_out, valid, busy, overrun, bit_cnt
  );

  modport slave (
    input  clear, shift, s_in, ack,
    output p_out, valid, busy, overrun, bit_cnt
  );
endinterface

// File: rtl/sipo_bit_counter.sv
// Bit counter for one serial word; wraps to 0 on the increment that completes the word.
// tc is combinational (cnt == WIDTH-1 && inc) so the parent can capture the word on that same edge.
module sipo_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  assign tc = inc && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || tc) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sipo_collector.sv
// SIPO collector: p_out/valid update on the edge sampling the last bit; valid/ack handshake, sticky overrun.
// Default LSB-first; define SIPO_MSB_FIRST_EN for MSB-first assembly.
module sipo_collector
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic reset_n,
  sipo_collector_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  logic             inc;
  logic             complete;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;
  logic [WIDTH-1:0] p_out_q;
  logic             valid_q;
  logic             busy_q;
  logic             overrun_q;

  // clear outranks shift, so a shift under clear is not counted
  assign inc = bus.shift && !bus.clear;

`ifdef SIPO_MSB_FIRST_EN
  assign sr_shifted = {sr[WIDTH-2:0], bus.s_in};
`else
  assign sr_shifted = {bus.s_in, sr[WIDTH-1:1]};
`endif

  sipo_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (inc),
    .clr     (bus.clear),
    .cnt     (cnt),
    .tc      (complete)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = ST_IDLE;
    end else if (bus.shift) begin
      case (state)
        ST_IDLE:    state_nxt = ST_COLLECT;
        ST_COLLECT: state_nxt = complete ? ST_IDLE : ST_COLLECT;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr        <= '0;
      p_out_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (bus.clear) begin
        sr     <= '0;
        busy_q <= 1'b0;
      end else if (inc) begin
        sr     <= sr_shifted;
        busy_q <= !complete;
      end

      // A same-cycle ack consumes the old word, so the new one is not an overrun
      if (complete) begin
        p_out_q <= sr_shifted;
        valid_q <= 1'b1;
        if (valid_q && !bus.ack) begin
          overrun_q <= 1'b1;
        end
      end else if (bus.ack) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.p_out   = p_out_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;
  assign bus.bit_cnt = cnt;

endmodule

// File: tb/tb_sipo_collector.sv
// Directed bench for sipo_collector (WIDTH=4); expectations follow the build's bit order.
module tb_sipo_collector;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  sipo_collector_if #(.WIDTH(4), .CNT_W(5)) bus ();

  sipo_collector #(.WIDTH(4), .CNT_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

`ifdef SIPO_MSB_FIRST_EN
  localparam logic [3:0] EXP_1011_SEQ = 4'b1011;
  localparam logic [3:0] EXP_0001_SEQ = 4'b0001;
`else
  localparam logic [3:0] EXP_1011_SEQ = 4'b1101;
  localparam logic [3:0] EXP_0001_SEQ = 4'b1000;
`endif

  // Serial order in which the bits of a word must be sent so that p_out equals it
  function automatic int bit_idx(input int i);
`ifdef SIPO_MSB_FIRST_EN
    return 3 - i;
`else
    return i;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic a);
    bus.shift = 1'b1;
    bus.s_in  = b;
    bus.ack   = a;
    tick();
    bus.shift = 1'b0;
    bus.s_in  = 1'b0;
    bus.ack   = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) send_bit(w[bit_idx(i)], 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    checks++; if (bus.p_out !== 4'h0) $display("FAIL reset_p_out: got %h want %h", bus.p_out, 4'h0); else passed++;
    checks++; if (bus.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.valid); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", bus.overrun); else passed++;
    checks++; if (bus.bit_cnt !== 5'd0) $display("FAIL reset_bit_cnt: got %0d want 0", bus.bit_cnt); else passed++;
  endtask

  task automatic test_collect();
    send_bit(1'b1, 1'b0);
    tick();
    checks++; if (bus.bit_cnt !== 5'd1) $display("FAIL gap_bit_cnt: got %0d want 1", bus.bit_cnt); else passed++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL gap_busy: got %b want 1", bus.busy); else passed++;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    checks++; if (bus.bit_cnt !== 5'd3) $display("FAIL collect_bit_cnt3: got %0d want 3", bus.bit_cnt); else passed++;
    checks++; if (bus.valid !== 1'b0) $display("FAIL collect_early_valid: got %b want 0", bus.valid); else passed++;
    send_bit(1'b1, 1'b0);
    checks++; if (bus.p_out !== EXP_1011_SEQ) $display("FAIL collect_p_out: got %b want %b", bus.p_out, EXP_1011_SEQ); else passed++;
    checks++; if (bus.valid !== 1'b1) $display("FAIL collect_valid: got %b want 1", bus.valid); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL collect_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.bit_cnt !== 5'd0) $display("FAIL collect_bit_cnt: got %0d want 0", bus.bit_cnt); else passed++;
  endtask

  task automatic test_ack();
    tick();
    tick();
    checks++; if (bus.valid !== 1'b1) $display("FAIL ack_hold_valid: got %b want 1", bus.valid); else passed++;
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    checks++; if (bus.valid !== 1'b0) $display("FAIL ack_valid: got %b want 0", bus.valid); else passed++;
    checks++; if (bus.p_out !== EXP_1011_SEQ) $display("FAIL ack_p_out: got %b want %b", bus.p_out, EXP_1011_SEQ); else passed++;
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    checks++; if (bus.valid !== 1'b0) $display("FAIL idle_ack_valid: got %b want 0", bus.valid); else passed++;
    checks++; if (bus.overrun !== 1'b0) $display("FAIL idle_ack_overrun: got %b want 0", bus.overrun); else passed++;
  endtask

  task automatic test_overrun();
    send_word(4'hA);
    checks++; if (bus.p_out !== 4'hA) $display("FAIL ovr_first_p_out: got %h want a", bus.p_out); else passed++;
    checks++; if (bus.overrun !== 1'b0) $display("FAIL ovr_first_overrun: got %b want 0", bus.overrun); else passed++;
    send_word(4'h5);
    checks++; if (bus.p_out !== 4'h5) $display("FAIL ovr_p_out: got %h want 5", bus.p_out); else passed++;
    checks++; if (bus.valid !== 1'b1) $display("FAIL ovr_valid: got %b want 1", bus.valid); else passed++;
    checks++; if (bus.overrun !== 1'b1) $display("FAIL ovr_overrun: got %b want 1", bus.overrun); else passed++;
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    checks++; if (bus.valid !== 1'b0) $display("FAIL ovr_ack_valid: got %b want 0", bus.valid); else passed++;
    checks++; if (bus.overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", bus.overrun); else passed++;
  endtask

  task automatic test_clear();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    checks++; if (bus.bit_cnt !== 5'd0) $display("FAIL clr_bit_cnt: got %0d want 0", bus.bit_cnt); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL clr_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.p_out !== 4'h5) $display("FAIL clr_p_out: got %h want 5", bus.p_out); else passed++;
    checks++; if (bus.overrun !== 1'b1) $display("FAIL clr_overrun: got %b want 1", bus.overrun); else passed++;
    bus.clear = 1'b1;
    send_bit(1'b1, 1'b0);
    bus.clear = 1'b0;
    checks++; if (bus.bit_cnt !== 5'd0) $display("FAIL clr_over_shift: got %0d want 0", bus.bit_cnt); else passed++;
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    checks++; if (bus.p_out !== EXP_0001_SEQ) $display("FAIL clr_word: got %b want %b", bus.p_out, EXP_0001_SEQ); else passed++;
    checks++; if (bus.valid !== 1'b1) $display("FAIL clr_word_valid: got %b want 1", bus.valid); else passed++;
  endtask

  task automatic test_reset_mid();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if (bus.bit_cnt !== 5'd0) $display("FAIL rst_mid_bit_cnt: got %0d want 0", bus.bit_cnt); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.p_out !== 4'h0) $display("FAIL rst_mid_p_out: got %h want 0", bus.p_out); else passed++;
    checks++; if (bus.overrun !== 1'b0) $display("FAIL rst_mid_overrun: got %b want 0", bus.overrun); else passed++;
    send_word(4'hC);
    checks++; if (bus.p_out !== 4'hC) $display("FAIL rst_pre_p_out: got %h want c", bus.p_out); else passed++;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if (bus.valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.valid); else passed++;
    checks++; if (bus.p_out !== 4'h0) $display("FAIL rst_valid_p_out: got %h want 0", bus.p_out); else passed++;
  endtask

  task automatic test_ack_coincident();
    logic [3:0] w;
    w = 4'h6;
    send_word(4'h3);
    for (int i = 0; i < 3; i++) send_bit(w[bit_idx(i)], 1'b0);
    send_bit(w[bit_idx(3)], 1'b1);
    checks++; if (bus.valid !== 1'b1) $display("FAIL coinc_valid: got %b want 1", bus.valid); else passed++;
    checks++; if (bus.p_out !== 4'h6) $display("FAIL coinc_p_out: got %h want 6", bus.p_out); else passed++;
    checks++; if (bus.overrun !== 1'b0) $display("FAIL coinc_overrun: got %b want 0", bus.overrun); else passed++;
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    checks++; if (bus.valid !== 1'b0) $display("FAIL coinc_ack_valid: got %b want 0", bus.valid); else passed++;
  endtask

  initial begin
    bus.clear = 1'b0;
    bus.shift = 1'b0;
    bus.s_in  = 1'b0;
    bus.ack   = 1'b0;
    test_reset();
    test_collect();
    test_ack();
    test_overrun();
    test_clear();
    test_reset_mid();
    test_ack_coincident();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
